// File: rtl/adder_tree_accum_if.sv
// Handshake bundle between the adder tree producer, the batch accumulator and
// the downstream consumer of batch totals.
interface adder_tree_accum_if #(
    parameter int ADDER_WIDTH = 96,
    parameter int FRAMES      = 16
);
    localparam int IN_WIDTH  = ADDER_WIDTH + 1;
    localparam int CNT_WIDTH = $clog2(FRAMES);
    localparam int ACC_WIDTH = IN_WIDTH + CNT_WIDTH;

    logic                 in_valid;
    logic [IN_WIDTH-1:0]  in_sum;
    logic                 clear;
    logic                 out_ready;
    logic                 out_valid;
    logic [ACC_WIDTH-1:0] out_total;
    logic                 busy;
    logic                 overrun;

    // The master is the environment that feeds sums and drains totals.
    modport master (
        output in_valid, in_sum, clear, out_ready,
        input  out_valid, out_total, busy, overrun
    );

    modport slave (
        input  in_valid, in_sum, clear, out_ready,
        output out_valid, out_total, busy, overrun
    );
endinterface

// File: rtl/adder_tree_accum.sv
// Accumulates FRAMES consecutive adder-tree sums into one batch total and
// presents it on a single-entry valid/ready slot with a sticky overrun flag.
module adder_tree_accum #(
    parameter int ADDER_WIDTH = 96,
    parameter int FRAMES      = 16
) (
    input logic               clk,
    input logic               rst,
    adder_tree_accum_if.slave acc_if
);
    localparam int IN_WIDTH  = ADDER_WIDTH + 1;
    localparam int CNT_WIDTH = $clog2(FRAMES);
    localparam int ACC_WIDTH = IN_WIDTH + CNT_WIDTH;
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(FRAMES - 1);

    typedef enum logic {
        ACC_IDLE,
        ACC_RUN
    } accState_t;

    typedef enum logic {
        SLOT_EMPTY,
        SLOT_FULL
    } slotState_t;

    accState_t            accState_q, accState_d;
    slotState_t           slotState_q, slotState_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [ACC_WIDTH-1:0] total_q, total_d;
    logic                 overrun_q, overrun_d;

    logic [ACC_WIDTH-1:0] batchSum;
    logic                 accept;
    logic                 lastSample;
    logic                 slotFree;
    logic                 load;

    assign batchSum   = acc_q + ACC_WIDTH'(acc_if.in_sum);
    assign accept     = acc_if.in_valid && !acc_if.clear;
    assign lastSample = (cnt_q == LAST_CNT);
    // A drain in the same cycle frees the slot, so the new total can take its place.
    assign slotFree   = (slotState_q == SLOT_EMPTY) || acc_if.out_ready;
    assign load       = accept && lastSample && slotFree;

    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        total_d     = total_q;
        overrun_d   = overrun_q;
        slotState_d = slotState_q;

        if (acc_if.clear) begin
            acc_d     = '0;
            cnt_d     = '0;
            overrun_d = 1'b0;
        end else if (accept) begin
            if (lastSample) begin
                acc_d = '0;
                cnt_d = '0;
                if (!slotFree) begin
                    overrun_d = 1'b1;
                end
            end else begin
                acc_d = batchSum;
                cnt_d = cnt_q + 1'b1;
            end
        end

        if (load) begin
            total_d     = batchSum;
            slotState_d = SLOT_FULL;
        end else if (acc_if.out_ready) begin
            slotState_d = SLOT_EMPTY;
        end

        accState_d = (cnt_d == '0) ? ACC_IDLE : ACC_RUN;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            accState_q  <= ACC_IDLE;
            slotState_q <= SLOT_EMPTY;
            acc_q       <= '0;
            cnt_q       <= '0;
            total_q     <= '0;
            overrun_q   <= 1'b0;
        end else begin
            accState_q  <= accState_d;
            slotState_q <= slotState_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            total_q     <= total_d;
            overrun_q   <= overrun_d;
        end
    end

    assign acc_if.out_valid = (slotState_q == SLOT_FULL);
    assign acc_if.out_total = total_q;
    assign acc_if.busy      = (accState_q == ACC_RUN);
    assign acc_if.overrun   = overrun_q;
endmodule

// File: doc/adder_tree_accum.md
# adder_tree_accum

Downstream consumer of the 3-level adder tree. It takes the tree's registered sum (ADDER_WIDTH+1 bits) whenever the producer flags it valid, and accumulates FRAMES consecutive valid sums into one batch total. Each total is presented on a one-entry valid/ready output slot. Loss is flagged with a sticky overrun bit when the slot cannot be drained in time.

## Interface
- ADDER_WIDTH, 96: operand width of the upstream tree.
- IN_WIDTH, ADDER_WIDTH+1: width of the tree output `sum`.
- FRAMES, 16: sums per batch. Must be a power of two, at least 2.
- CNT_WIDTH, $clog2(FRAMES): width of the batch counter.
- ACC_WIDTH, IN_WIDTH+CNT_WIDTH: width of the accumulator and of `out_total`.

Ports:
- clk, input, 1: single clock. All logic is rising-edge.
- rst, input, 1: asynchronous, active-high reset.
- in_valid, input, 1: `in_sum` is a valid tree result this cycle. The producer aligns it to the tree's 2-cycle input-to-sum latency.
- in_sum, input, IN_WIDTH: unsigned tree sum.
- clear, input, 1: synchronous abort of the partial batch.
- out_valid, output, 1: the output slot holds a batch total.
- out_ready, input, 1: the consumer accepts the slot this cycle.
- out_total, output, ACC_WIDTH: unsigned batch total.
- busy, output, 1: a partial batch is in progress (counter not zero).
- overrun, output, 1: sticky. A completed batch was dropped.

## Operation
- All arithmetic is unsigned with zero-extension. ACC_WIDTH guarantees FRAMES × (2^IN_WIDTH − 1) cannot wrap.
- Internal state: `acc` (ACC_WIDTH bits) and `cnt` (CNT_WIDTH bits). Accumulator state machine:
  - IDLE: `cnt` is 0.
  - RUN: `cnt` is 1 to FRAMES−1.
- When in_valid=1, clear=0 and `cnt` < FRAMES−1: `acc` ← `acc` + `in_sum`, `cnt` ← `cnt`+1.
- When in_valid=1, clear=0 and `cnt` = FRAMES−1 (batch completes): total = `acc` + `in_sum`; `acc` ← 0; `cnt` ← 0 (back to IDLE).
  - If the slot is empty, or is being drained this cycle (out_valid & out_ready), the total loads the slot and out_valid ← 1.
  - Otherwise the total is dropped, overrun ← 1, and the slot keeps its old value.
- When in_valid=0, `acc` and `cnt` hold. Gaps inside a batch are legal and unbounded.
- clear=1 sets `acc` ← 0, `cnt` ← 0 and overrun ← 0. Clear wins over a simultaneous in_valid, and that sample is discarded. The output slot is not affected.
- Output slot states:
  - EMPTY→FULL on a load.
  - FULL→EMPTY on out_ready with no simultaneous load.
  - FULL→FULL with the new value on a drain plus load in the same cycle.
  - out_ready while EMPTY is ignored.
  - out_total is stable while out_valid=1 and out_ready=0.
- busy = (`cnt` ≠ 0).

## Timing
- Reset values: out_valid=0, out_total=0, busy=0, overrun=0, `acc`=0, `cnt`=0. Reset takes effect immediately and asynchronously, including mid-batch or with the slot full. Pending data is lost.
- Latency: when the final sample of a batch is accepted at edge t, out_valid=1 and out_total are visible after edge t, i.e. one cycle.
- Throughput: one in_sum per cycle with no bubbles. A batch completes every FRAMES cycles at most.
- overrun is set on the edge that drops a batch. It stays set until rst or clear.
- busy rises after the first accepted sample of a batch and falls after the final one.
- There is no combinational path from in_* or out_ready to any output. All outputs are registered.

## Test plan
All scenarios use FRAMES=4, ADDER_WIDTH=96 (IN_WIDTH=97, ACC_WIDTH=99).
- Reset with all inputs idle -> out_valid=0, out_total=0, busy=0, overrun=0. Assert rst asynchronously mid-batch after samples 7 and 9 -> busy=0 immediately; the next batch 1,1,1,1 gives out_total=4.
- Back-to-back in_sum=1,2,3,4 with out_ready=1 -> out_valid=1 with out_total=10 for exactly one cycle, starting the cycle after sample 4. busy is 1 after samples 1–3 and 0 after sample 4.
- Max values: four samples of 2^97−1 -> out_total=2^99−4 with no wrap. Repeat the batch with two idle cycles between samples -> same total.
- Backpressure with out_ready=0: batch 1,1,1,1 then batch 2,2,2,2 -> slot holds 4, overrun=1 after the 8th sample. Raise out_ready -> slot drains 4, then out_valid=0. overrun stays 1 until clear.
- Slot holds 4; the final sample of batch 2,2,2,2 arrives in the same cycle as out_ready=1 -> out_valid stays 1, out_total=8, overrun=0.
- Samples 5,5, then clear=1 together with in_valid=1 and in_sum=5, then samples 1,1,1,1 -> the 5s are discarded and out_total=4. A slot value loaded before the clear is still delivered.
